// File: rtl/fpalu_pkg.sv
// Shared FPALU formats, constants and per-stage records for the FP16 output packer.
package fpalu_pkg;

    localparam int AL_MANSIZE = 22;
    localparam int AL_EXPSIZE = 6;
    localparam int FP29I_BIAS = 30;
    localparam int FP16_BIAS  = 15;

    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    localparam int LZD_W        = 6;
    localparam int FP16_EXP_INF = 2 * FP16_BIAS + 1;
    localparam int SUB_SH_MAX   = 12;
    // mantissa bit21 carries weight 2^1, so the rebias needs one extra -1
    localparam int E16_OFS      = FP29I_BIAS - FP16_BIAS - 1;

    typedef struct packed {
        logic                  sgn;
        logic [AL_EXPSIZE-1:0] exp;
        logic [AL_MANSIZE-1:0] man;
        logic [4:0]            lzd;
    } s1_t;

    typedef struct packed {
        logic                  sgn;
        logic [7:0]            e16;
        logic [AL_MANSIZE-1:0] man;
        logic                  sticky;
    } s2_t;

    typedef struct packed {
        logic [15:0] fp16;
        logic        ovf;
        logic        inexact;
    } s3_t;

endpackage

// File: rtl/count_lead_zero.sv
// Combinational leading-zero counter; returns W_IN for an all-zero input.
module count_lead_zero #(
    parameter int W_IN  = 32,
    parameter int W_OUT = $clog2(W_IN + 1)
) (
    input  logic [W_IN-1:0]  din,
    output logic [W_OUT-1:0] cnt
);

    always_comb begin
        cnt = W_OUT'(W_IN);
        for (int i = 0; i < W_IN; i++) begin
            if (din[i]) cnt = W_OUT'(W_IN - 1 - i);
        end
    end

endmodule

// File: rtl/fp29i_pack_fp16.sv
// FP29i -> IEEE FP16 packer: normalize, RNE round, overflow / subnormal / signed-zero handling.
// 3-cycle latency, 1 word/cycle; a stage stalls only when occupied and the stage ahead is blocked.
module fp29i_pack_fp16
    import fpalu_pkg::*;
#(
    parameter bit SAT_OVF = 1'b0,
    parameter bit FTZ     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sgn,
    input  logic [AL_EXPSIZE-1:0] in_exp,
    input  logic [AL_MANSIZE-1:0] in_man_dn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_fp16,
    output logic                  out_ovf,
    output logic                  out_inexact
);

    s1_t  s1, s1_d;
    s2_t  s2, s2_d;
    s3_t  s3, s3_d;
    logic s1v, s2v, s3v;
    logic ld1, ld2, ld3;

    assign ld3      = ~s3v | out_ready;
    assign ld2      = ~s2v | ld3;
    assign ld1      = ~s1v | ld2;
    assign in_ready = ld1;

    logic [LZD_W-1:0] clz;

    count_lead_zero #(.W_IN(32), .W_OUT(LZD_W)) u_clz (
        .din ({in_man_dn, 10'b0}),
        .cnt (clz)
    );

    always_comb begin
        s1_d.sgn = in_sgn;
        s1_d.exp = in_exp;
        s1_d.man = in_man_dn;
        s1_d.lzd = (clz > LZD_W'(AL_MANSIZE)) ? 5'(AL_MANSIZE) : clz[4:0];
    end

    logic [AL_MANSIZE-1:0] man_n;
    logic [7:0]            e16_raw;
    logic [7:0]            sh_full;
    logic [3:0]            sh;
    logic                  sub;

    always_comb begin
        man_n   = s1.man << s1.lzd;
        e16_raw = {2'b00, s1.exp} - 8'(E16_OFS) - {3'b000, s1.lzd};
        sub     = e16_raw[7] | (e16_raw == 8'd0);
        sh_full = 8'd1 - e16_raw;
        sh      = (sh_full > 8'(SUB_SH_MAX)) ? 4'(SUB_SH_MAX) : sh_full[3:0];

        s2_d.sgn    = s1.sgn;
        s2_d.e16    = e16_raw;
        s2_d.man    = man_n;
        s2_d.sticky = 1'b0;
        if (s1.man == '0) begin
            s2_d.e16 = '0;
            s2_d.man = '0;
        end else if (sub) begin
            // denormalize so bits [20:11] hold the FP16 subnormal fraction
            s2_d.man    = man_n >> sh;
            s2_d.sticky = |(man_n & ~({AL_MANSIZE{1'b1}} << sh));
            s2_d.e16    = '0;
        end
    end

    logic        guard, sticky, rnd;
    logic [7:0]  e_base, e_out;
    logic [17:0] mag;

    always_comb begin
        guard  = s2.man[10];
        sticky = (|s2.man[9:0]) | s2.sticky;
        rnd    = guard & (sticky | s2.man[11]);
        // no hidden bit means subnormal or zero: exponent field is 0
        e_base = s2.man[AL_MANSIZE-1] ? s2.e16 : 8'd0;
        // fraction carry ripples straight into the exponent field
        mag    = {e_base, s2.man[20:11]} + 18'(rnd);
        e_out  = mag[17:10];

        s3_d.fp16    = {s2.sgn, mag[14:0]};
        s3_d.ovf     = 1'b0;
        s3_d.inexact = guard | sticky;
        if (e_out >= 8'(FP16_EXP_INF)) begin
            s3_d.ovf  = 1'b1;
            s3_d.fp16 = {s2.sgn, SAT_OVF ? FP16_MAXF[14:0] : FP16_INF[14:0]};
        end else if (FTZ && (e_out == 8'd0) && (mag[9:0] != 10'd0)) begin
            s3_d.fp16    = {s2.sgn, 15'd0};
            s3_d.inexact = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
            s3v <= 1'b0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
        end else begin
            if (ld1) begin
                s1v <= in_valid;
                if (in_valid) s1 <= s1_d;
            end
            if (ld2) begin
                s2v <= s1v;
                if (s1v) s2 <= s2_d;
            end
            if (ld3) begin
                s3v <= s2v;
                if (s2v) s3 <= s3_d;
            end
        end
    end

    assign out_valid   = s3v;
    assign out_fp16    = s3.fp16;
    assign out_ovf     = s3.ovf;
    assign out_inexact = s3.inexact;

endmodule

// File: tb/tb_fp29i_pack_fp16.sv
// Bench for fp29i_pack_fp16: directed vector table, random stream vs. exact-arithmetic model, backpressure and reset.
module tb_fp29i_pack_fp16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_sgn, out_ready;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        in_ready, out_valid, out_ovf, out_inexact;
    logic [15:0] out_fp16;
    logic        in_ready_alt, out_valid_alt, out_ovf_alt, out_inexact_alt;
    logic [15:0] out_fp16_alt;

    fp29i_pack_fp16 #(.SAT_OVF(1'b0), .FTZ(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp16(out_fp16),
        .out_ovf(out_ovf), .out_inexact(out_inexact));

    fp29i_pack_fp16 #(.SAT_OVF(1'b1), .FTZ(1'b1)) dut_alt (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_alt),
        .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
        .out_valid(out_valid_alt), .out_ready(out_ready), .out_fp16(out_fp16_alt),
        .out_ovf(out_ovf_alt), .out_inexact(out_inexact_alt));

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;
    logic [17:0] exp_q[$];
    logic [17:0] alt_q[$];
    bit          hold_pend = 1'b0;
    logic [18:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, want);
    endtask

    // Exact model: value = m * 2^(e-50); quantize to the FP16 grid at the value's binade.
    function automatic logic [17:0] ref_word(input logic s, input logic [5:0] e,
                                             input logic [21:0] m, input bit sat, input bit ftz);
        longint     n, rem, half;
        int         p, ex, k;
        logic [15:0] code;
        bit         inx, ovf;
        if (m == 22'd0) return {s, 15'd0, 2'b00};
        p = 21;
        while (m[p] == 1'b0) p--;
        ex = p + int'(e) - 50;
        if (ex < -14) ex = -14;
        k = int'(e) - 40 - ex;
        rem = 0;
        if (k >= 0) begin
            n = longint'(m) << k;
        end else begin
            n    = longint'(m) >> (-k);
            rem  = longint'(m) & ((64'sd1 << (-k)) - 1);
            half = 64'sd1 << (-k - 1);
            if (rem > half || (rem == half && n[0])) n++;
        end
        inx = (rem != 0);
        ovf = 1'b0;
        if (n == 2048) begin
            n = 1024;
            ex++;
        end
        if (n >= 1024 && ex + 15 >= 31) begin
            ovf  = 1'b1;
            code = sat ? 16'h7BFF : 16'h7C00;
        end else if (n >= 1024) begin
            code = 16'((longint'(ex + 15) << 10) | (n - 1024));
        end else begin
            code = 16'(n);
        end
        if (ftz && code[14:10] == 5'd0 && code != 16'd0) begin
            code = 16'd0;
            inx  = 1'b1;
        end
        return {s, code[14:0], ovf, inx};
    endfunction

    task automatic drive_rand();
        in_sgn    = 1'($urandom_range(0, 1));
        in_exp    = 6'($urandom_range(0, 63));
        in_man_dn = 22'($urandom() >> $urandom_range(10, 32));
    endtask

    task automatic send_one(input logic s, input logic [5:0] e, input logic [21:0] m,
                            output logic [17:0] got, output logic [17:0] got_alt, output int lat);
        @(posedge clk); #1;
        in_sgn = s; in_exp = e; in_man_dn = m; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        got     = {out_fp16, out_ovf, out_inexact};
        got_alt = {out_fp16_alt, out_ovf_alt, out_inexact_alt};
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (hold_pend) chk("hold_stable", {13'd0, out_valid, out_fp16, out_ovf, out_inexact}, {13'd0, held});
            hold_pend = out_valid && !out_ready;
            held      = {1'b1, out_fp16, out_ovf, out_inexact};
            if (!in_ready) chk("stall_only_when_full", 32'(exp_q.size()), 32'd3);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0 || alt_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got word %h with empty scoreboard", out_fp16);
                end else begin
                    chk("stream_word", {14'd0, out_fp16, out_ovf, out_inexact}, {14'd0, exp_q.pop_front()});
                    chk("stream_word_alt", {14'd0, out_fp16_alt, out_ovf_alt, out_inexact_alt}, {14'd0, alt_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_word(in_sgn, in_exp, in_man_dn, 1'b0, 1'b0));
                alt_q.push_back(ref_word(in_sgn, in_exp, in_man_dn, 1'b1, 1'b1));
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s;
        logic [5:0]  e;
        logic [21:0] m;
        logic [17:0] want;
        logic [17:0] want_alt;
    } vec_t;

    vec_t        vecs[18];
    logic [17:0] got, got_alt;
    int          lat, sent, stalls;
    bit          fire;

    initial begin
        // {fp16, ovf, inexact} for SAT_OVF=0/FTZ=0 and for SAT_OVF=1/FTZ=1
        vecs[0]  = '{1'b0, 6'd30, 22'h100000, {16'h3C00, 2'b00}, {16'h3C00, 2'b00}};
        vecs[1]  = '{1'b0, 6'd30, 22'h200000, {16'h4000, 2'b00}, {16'h4000, 2'b00}};
        vecs[2]  = '{1'b0, 6'd30, 22'h100200, {16'h3C00, 2'b01}, {16'h3C00, 2'b01}};
        vecs[3]  = '{1'b0, 6'd30, 22'h100600, {16'h3C02, 2'b01}, {16'h3C02, 2'b01}};
        vecs[4]  = '{1'b1, 6'd63, 22'h200000, {16'hFC00, 2'b10}, {16'hFBFF, 2'b10}};
        vecs[5]  = '{1'b0, 6'd6,  22'h100000, {16'h0001, 2'b00}, {16'h0000, 2'b01}};
        vecs[6]  = '{1'b0, 6'd0,  22'h000001, {16'h0000, 2'b01}, {16'h0000, 2'b01}};
        vecs[7]  = '{1'b1, 6'd17, 22'h000000, {16'h8000, 2'b00}, {16'h8000, 2'b00}};
        // e45 is the smallest exponent where this mantissa rounds past max finite
        vecs[8]  = '{1'b0, 6'd45, 22'h1FFFFF, {16'h7C00, 2'b11}, {16'h7BFF, 2'b11}};
        vecs[9]  = '{1'b0, 6'd44, 22'h1FFFFF, {16'h7800, 2'b01}, {16'h7800, 2'b01}};
        vecs[10] = '{1'b0, 6'd15, 22'h1FFC00, {16'h0400, 2'b01}, {16'h0400, 2'b01}};
        vecs[11] = '{1'b0, 6'd15, 22'h1FF800, {16'h03FF, 2'b00}, {16'h0000, 2'b01}};
        vecs[12] = '{1'b0, 6'd44, 22'h3FF800, {16'h7BFF, 2'b00}, {16'h7BFF, 2'b00}};
        vecs[13] = '{1'b0, 6'd15, 22'h200000, {16'h0400, 2'b00}, {16'h0400, 2'b00}};
        vecs[14] = '{1'b1, 6'd6,  22'h100000, {16'h8001, 2'b00}, {16'h8000, 2'b01}};
        vecs[15] = '{1'b0, 6'd4,  22'h200001, {16'h0001, 2'b01}, {16'h0000, 2'b01}};
        vecs[16] = '{1'b0, 6'd4,  22'h200000, {16'h0000, 2'b01}, {16'h0000, 2'b01}};
        vecs[17] = '{1'b1, 6'd30, 22'h100400, {16'hBC01, 2'b00}, {16'hBC01, 2'b00}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sgn = 1'b0; in_exp = '0; in_man_dn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_word", {14'd0, out_fp16, out_ovf, out_inexact}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            send_one(vecs[i].s, vecs[i].e, vecs[i].m, got, got_alt, lat);
            chk($sformatf("vec%0d_word", i), 32'(got), 32'(vecs[i].want));
            chk($sformatf("vec%0d_word_alt", i), 32'(got_alt), 32'(vecs[i].want_alt));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_alt_handshake", i), {30'd0, out_valid_alt, in_ready_alt}, 32'd3);
        end

        // random stream with random backpressure
        @(posedge clk); #1;
        mon_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                drive_rand();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("random_drain", 32'(exp_q.size()), 32'd0);

        // 8-word burst, out_ready low during cycles 4..7
        sent = 0; stalls = 0;
        drive_rand(); in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            @(negedge clk);
            fire = in_valid && in_ready;
            if (in_valid && !in_ready) stalls++;
            @(posedge clk); #1;
            if (fire) begin
                sent++;
                if (sent < 8) drive_rand();
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_stall_cycles", 32'(stalls), 32'd4);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);

        // reset with a full pipe
        out_ready = 1'b0;
        drive_rand(); in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_word", {14'd0, out_fp16, out_ovf, out_inexact}, 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        exp_q.delete(); alt_q.delete();
        send_one(1'b0, 6'd31, 22'h180000, got, got_alt, lat);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("post_reset_word", 32'(got), 32'(ref_word(1'b0, 6'd31, 22'h180000, 1'b0, 1'b0)));
        @(posedge clk); #1;
        chk("post_reset_no_extra", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
